// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared definitions for the data-memory load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - alignment and funct3 legality helpers
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Halves need an even offset, words a zero offset; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                     (funct3 == F3_BU) || (funct3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational lane handling for the load/store unit.
//   funct3   in  3   access size / signedness
//   off      in  2   byte offset inside the word (addr[1:0])
//   word     in  32  word read from memory
//   wdata    in  32  store data (low byte/half used for SB/SH)
//   rdata    out 32  extracted and extended load data
//   merged   out 32  word with the store lane replaced, other lanes from word
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    assign sh   = {off, 3'b000};
    // Shift the selected lane down to bit 0; alignment is already checked,
    // so a half never straddles the word.
    assign lane = word >> sh;

    always_comb begin
        rdata = lane;
        case (funct3)
            F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   rdata = {24'h0, lane[7:0]};
            F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   rdata = {16'h0, lane[15:0]};
            default: rdata = word;
        endcase
    end

    always_comb begin
        mask   = 32'hFFFF_FFFF;
        merged = wdata;
        case (funct3[1:0])
            2'b00: begin
                mask   = 32'h0000_00FF << sh;
                merged = (word & ~mask) | (({24'h0, wdata[7:0]} << sh) & mask);
            end
            2'b01: begin
                mask   = 32'h0000_FFFF << sh;
                merged = (word & ~mask) | (({16'h0, wdata[15:0]} << sh) & mask);
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store initiator for a word-wide data memory.
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we/req_funct3/req_addr/req_wdata   request payload
//   rsp_valid/rsp_ready          response handshake, held until accepted
//   rsp_rdata/rsp_err            extended load data / error flag
//   mem_we/mem_addr/mem_wdata    word-aligned memory interface
//   mem_rdata                    combinational memory read of mem_addr
// Sub-word stores are read-modify-write because the memory writes whole words.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        req_bad;

    lsu_align u_align (
        .funct3 (funct3_q),
        .off    (addr_q[1:0]),
        .word   (mem_rdata),
        .wdata  (wdata_q),
        .rdata  (load_data),
        .merged (merged_word)
    );

    assign req_bad = !is_legal_f3(req_we, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]) ||
                     (req_addr >= 32'(DMEM_BYTES));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = 32'h0;
                    if (req_bad) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    // wdata_q doubles as the write-back word for the WRITE cycle.
                    wdata_d = merged_word;
                    state_d = WRITE;
                end else begin
                    rsp_rdata_d = load_data;
                    state_d     = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rsp_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // mem_we comes straight from state so reset kills a pending write at once.
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed + random checks of dmem_lsu against a byte-array
// reference model, with a 1024-word memory attached to the memory port.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];
    logic        fill = 1'b1;

    always #5 clk = ~clk;

    dmem_lsu #(.DMEM_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 8)  return 32'h8899AABB;
        if (i == 12) return 32'h11223344;
        return i * 32'h9E3779B9 + 32'h01234567;
    endfunction

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    function automatic logic [31:0] ref_word(input int unsigned a);
        int unsigned b;
        b = a & 32'hFFC;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: applies the access rules to a byte array.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit err, output logic [31:0] rd,
                         output int lat, output int wes);
        int size;
        bit illegal;
        longint unsigned v;
        size    = 1 << f3[1:0];
        illegal = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
        err     = illegal || (a >= 4096) || ((a % size) != 0);
        rd = 32'h0; lat = 1; wes = 0;
        if (err) return;
        if (!we) begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(ref_b[a+i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 1);
            rd  = v[31:0];
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++) ref_b[a+i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 3;
            wes = 1;
        end
    endtask

    // Issues one request from a negedge and follows it through the response
    // handshake, holding rsp_ready low for 'hold' cycles.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, output logic [31:0] got);
        bit e_err; logic [31:0] e_rd; int e_lat, e_wes;
        int lat, wes, n;
        logic [31:0] held;
        model(we, f3, a, wd, e_err, e_rd, e_lat, e_wes);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 1; wes = 0;
        while (!rsp_valid && lat < 20) begin
            wes += int'(mem_we);
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", lat, e_lat);
        chk("mem_we_cycles", wes, e_wes);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
        chk("rsp_rdata", rsp_rdata, e_rd);
        got  = rsp_rdata;
        held = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, held);
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("post_hs_req_ready", {31'h0, req_ready}, 32'h1);
        chk("post_hs_rsp_err", {31'h0, rsp_err}, 32'h0);
        if (a < 4096) chk("mem_word", mem[a[11:2]], ref_word(a));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] old;
        int wes;
        int bad;
        for (int i = 0; i < 1024; i++) begin
            old = init_word(i);
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = old[8*k +: 8];
        end

        // Reset values
        #3;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        fill = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 1. SW then LW
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, got);
        chk("t1_lw", got, 32'hDEADBEEF);

        // 2. byte/half loads with extension
        do_req(1'b0, 3'b000, 32'h21, 32'h0, 0, got); chk("t2_lb", got, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h21, 32'h0, 0, got); chk("t2_lbu", got, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 0, got); chk("t2_lh", got, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 0, got); chk("t2_lhu", got, 32'h00008899);

        // 3. read-modify-write stores
        do_req(1'b1, 3'b000, 32'h32, 32'h000000EE, 0, got);
        chk("t3_sb_word", mem[12], 32'h11EE3344);
        do_req(1'b1, 3'b001, 32'h30, 32'h0000CAFE, 0, got);
        chk("t3_sh_word", mem[12], 32'h11EECAFE);

        // 4. errors
        do_req(1'b0, 3'b010, 32'h13, 32'h0, 0, got);
        do_req(1'b1, 3'b001, 32'h41, 32'h12345678, 0, got);
        do_req(1'b0, 3'b000, 32'h1000, 32'h0, 0, got);
        do_req(1'b0, 3'b011, 32'h40, 32'h0, 0, got);
        do_req(1'b1, 3'b100, 32'h40, 32'h0, 0, got);

        // 5. backpressure
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 5, got);
        do_req(1'b1, 3'b011, 32'h44, 32'h0, 5, got);

        // 6. reset during the READ of an SB
        old = mem[20];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h51; req_wdata = 32'h000000A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("t6_rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("t6_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("t6_rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wes = 0;
        for (int i = 0; i < 4; i++) begin
            wes += int'(mem_we);
            @(negedge clk);
        end
        chk("t6_no_write", wes, 0);
        chk("t6_word_unchanged", mem[20], old);
        chk("t6_req_ready", {31'h0, req_ready}, 32'h1);

        // Random traffic
        for (int r = 0; r < 60; r++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 8191)
                                            : 32'($urandom_range(0, 4095));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom_range(0, 2), got);
        end

        // Whole memory against the model
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_word(4*i)) bad++;
        chk("final_mem_diff_words", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
